// File: rtl/mem_pkg.sv
// Shared definitions for the load/store stage: funct3 size codes, FSM states
// and store-lane helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        MEM_IDLE,
        MEM_ACCESS
    } mem_state_e;

    // Unlisted store sizes behave as a full word.
    function automatic logic [3:0] store_byteen(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B:    return 4'b0001 << a;
            F3_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            F3_B:    return {4{sd[7:0]}};
            F3_H:    return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends
// it according to funct3; unlisted codes return the whole word.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: drives the data-cache handshake, stalls upstream for every
// access and registers the writeback bundle. MEM_MISALIGN_TRAP_EN adds misalign.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_write_reg_en,
    input  logic [4:0]  ex_write_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_writedata,
    output logic [3:0]  dmem_byteen,
    input  logic [31:0] dmem_readdata,
    input  logic        dmem_busywait,
    output logic        stall,
    output logic        wb_write_reg_en,
    output logic [4:0]  wb_write_address,
    output logic [31:0] wb_write_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    mem_state_e  state_q, state_d;
    logic        dmem_read_q, dmem_read_d;
    logic        dmem_write_q, dmem_write_d;
    logic [31:0] dmem_address_q, dmem_address_d;
    logic [31:0] dmem_writedata_q, dmem_writedata_d;
    logic [3:0]  dmem_byteen_q, dmem_byteen_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_en_q, rd_en_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;

    logic        mem_op;
    logic        bad_align;
    logic [31:0] load_data;

    mem_load_align u_align (
        .rdata     (dmem_readdata),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .load_data (load_data)
    );

    assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    // A load wins over a simultaneous store, so the load size table decides.
    always_comb begin
        bad_align = 1'b0;
        if (ex_mem_read) begin
            case (ex_funct3)
                F3_B, F3_BU: bad_align = 1'b0;
                F3_H, F3_HU: bad_align = ex_alu_result[0];
                default:     bad_align = (ex_alu_result[1:0] != 2'b00);
            endcase
        end else begin
            case (ex_funct3)
                F3_B:    bad_align = 1'b0;
                F3_H:    bad_align = ex_alu_result[0];
                default: bad_align = (ex_alu_result[1:0] != 2'b00);
            endcase
        end
    end
    assign misalign = misalign_q;
`else
    assign bad_align = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        dmem_read_d      = dmem_read_q;
        dmem_write_d     = dmem_write_q;
        dmem_address_d   = dmem_address_q;
        dmem_writedata_d = dmem_writedata_q;
        dmem_byteen_d    = dmem_byteen_q;
        addr_lo_d        = addr_lo_q;
        funct3_d         = funct3_q;
        rd_d             = rd_q;
        rd_en_d          = rd_en_q;
        wb_en_d          = 1'b0;
        wb_addr_d        = wb_addr_q;
        wb_data_d        = wb_data_q;
        misalign_d       = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (mem_op) begin
                    if (bad_align) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d        = MEM_ACCESS;
                        dmem_read_d    = ex_mem_read;
                        dmem_write_d   = ex_mem_write & ~ex_mem_read;
                        dmem_address_d = {ex_alu_result[31:2], 2'b00};
                        if (ex_mem_read) begin
                            dmem_byteen_d    = 4'b0000;
                            dmem_writedata_d = '0;
                        end else begin
                            dmem_byteen_d    = store_byteen(ex_funct3, ex_alu_result[1:0]);
                            dmem_writedata_d = store_lanes(ex_funct3, ex_store_data);
                        end
                        addr_lo_d = ex_alu_result[1:0];
                        funct3_d  = ex_funct3;
                        rd_d      = ex_write_address;
                        rd_en_d   = ex_write_reg_en;
                    end
                end else begin
                    wb_en_d   = ex_valid & ex_write_reg_en;
                    wb_addr_d = ex_write_address;
                    wb_data_d = ex_alu_result;
                end
            end
            MEM_ACCESS: begin
                if (!dmem_busywait) begin
                    state_d       = MEM_IDLE;
                    dmem_read_d   = 1'b0;
                    dmem_write_d  = 1'b0;
                    dmem_byteen_d = 4'b0000;
                    if (dmem_read_q) begin
                        wb_en_d   = rd_en_q;
                        wb_addr_d = rd_q;
                        wb_data_d = load_data;
                    end
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= MEM_IDLE;
            dmem_read_q      <= 1'b0;
            dmem_write_q     <= 1'b0;
            dmem_address_q   <= '0;
            dmem_writedata_q <= '0;
            dmem_byteen_q    <= '0;
            addr_lo_q        <= '0;
            funct3_q         <= '0;
            rd_q             <= '0;
            rd_en_q          <= 1'b0;
            wb_en_q          <= 1'b0;
            wb_addr_q        <= '0;
            wb_data_q        <= '0;
            misalign_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            dmem_read_q      <= dmem_read_d;
            dmem_write_q     <= dmem_write_d;
            dmem_address_q   <= dmem_address_d;
            dmem_writedata_q <= dmem_writedata_d;
            dmem_byteen_q    <= dmem_byteen_d;
            addr_lo_q        <= addr_lo_d;
            funct3_q         <= funct3_d;
            rd_q             <= rd_d;
            rd_en_q          <= rd_en_d;
            wb_en_q          <= wb_en_d;
            wb_addr_q        <= wb_addr_d;
            wb_data_q        <= wb_data_d;
            misalign_q       <= misalign_d;
        end
    end

    assign dmem_read        = dmem_read_q;
    assign dmem_write       = dmem_write_q;
    assign dmem_address     = dmem_address_q;
    assign dmem_writedata   = dmem_writedata_q;
    assign dmem_byteen      = dmem_byteen_q;
    assign stall            = (state_q == MEM_ACCESS);
    assign wb_write_reg_en  = wb_en_q;
    assign wb_write_address = wb_addr_q;
    assign wb_write_data    = wb_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; follows MEM_MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result, ex_store_data;
    logic        ex_write_reg_en;
    logic [4:0]  ex_write_address;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_writedata;
    logic [3:0]  dmem_byteen;
    logic [31:0] dmem_readdata;
    logic        dmem_busywait;
    logic        stall;
    logic        wb_write_reg_en;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_write_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_funct3        (ex_funct3),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_write_reg_en  (ex_write_reg_en),
        .ex_write_address (ex_write_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_writedata   (dmem_writedata),
        .dmem_byteen      (dmem_byteen),
        .dmem_readdata    (dmem_readdata),
        .dmem_busywait    (dmem_busywait),
        .stall            (stall),
        .wb_write_reg_en  (wb_write_reg_en),
        .wb_write_address (wb_write_address),
        .wb_write_data    (wb_write_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign         (misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic wen, input logic [4:0] rda);
        ex_valid         = v;
        ex_mem_read      = rd;
        ex_mem_write     = wr;
        ex_funct3        = f3;
        ex_alu_result    = alu;
        ex_store_data    = sd;
        ex_write_reg_en  = wen;
        ex_write_address = rda;
    endtask

    initial begin
        reset         = 1'b1;
        dmem_readdata = 32'h0;
        dmem_busywait = 1'b0;
        ex_set(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 5'd1);
        tick();
        tick();
        check("rst_read",   {31'h0, dmem_read}, 32'h0);
        check("rst_write",  {31'h0, dmem_write}, 32'h0);
        check("rst_stall",  {31'h0, stall}, 32'h0);
        check("rst_wb_en",  {31'h0, wb_write_reg_en}, 32'h0);
        check("rst_wb_dat", wb_write_data, 32'h0);
        check("rst_addr",   dmem_address, 32'h0);
        check("rst_byteen", {28'h0, dmem_byteen}, 32'h0);
        reset = 1'b0;

        // ADD x5 = 0x1234
        ex_set(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 1'b1, 5'd5);
        tick();
        check("add_wb_en",   {31'h0, wb_write_reg_en}, 32'h1);
        check("add_wb_addr", {27'h0, wb_write_address}, 32'd5);
        check("add_wb_data", wb_write_data, 32'h1234);
        check("add_stall",   {31'h0, stall}, 32'h0);
        ex_set(1'b0, 1'b0, 1'b0, 3'b000, 32'h9999, 32'h0, 1'b1, 5'd6);
        tick();
        check("inval_wb_en", {31'h0, wb_write_reg_en}, 32'h0);
        check("inval_stall", {31'h0, stall}, 32'h0);

        // LB at 0x103, zero-wait hit
        ex_set(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7);
        dmem_readdata = 32'h80FF_FF7F;
        dmem_busywait = 1'b0;
        tick();
        check("lb_stall",  {31'h0, stall}, 32'h1);
        check("lb_read",   {31'h0, dmem_read}, 32'h1);
        check("lb_write",  {31'h0, dmem_write}, 32'h0);
        check("lb_addr",   dmem_address, 32'h100);
        check("lb_bubble", {31'h0, wb_write_reg_en}, 32'h0);
        tick();
        check("lb_stall_end", {31'h0, stall}, 32'h0);
        check("lb_read_end",  {31'h0, dmem_read}, 32'h0);
        check("lb_wb_en",     {31'h0, wb_write_reg_en}, 32'h1);
        check("lb_wb_addr",   {27'h0, wb_write_address}, 32'd7);
        check("lb_wb_data",   wb_write_data, 32'hFFFF_FF80);

        // LHU at 0x102, three busy cycles, stale readdata while busy
        ex_set(1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 5'd9);
        dmem_readdata = 32'hDEAD_DEAD;
        dmem_busywait = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lhu_wait_stall", {31'h0, stall}, 32'h1);
            check("lhu_wait_read",  {31'h0, dmem_read}, 32'h1);
            check("lhu_wait_bub",   {31'h0, wb_write_reg_en}, 32'h0);
            tick();
        end
        check("lhu_stall4", {31'h0, stall}, 32'h1);
        check("lhu_read4",  {31'h0, dmem_read}, 32'h1);
        dmem_busywait = 1'b0;
        dmem_readdata = 32'hBEEF_0000;
        tick();
        check("lhu_stall_end", {31'h0, stall}, 32'h0);
        check("lhu_wb_en",     {31'h0, wb_write_reg_en}, 32'h1);
        check("lhu_wb_addr",   {27'h0, wb_write_address}, 32'd9);
        check("lhu_wb_data",   wb_write_data, 32'h0000_BEEF);

        // LBU at 0x101
        ex_set(1'b1, 1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 1'b1, 5'd10);
        dmem_readdata = 32'h0000_F500;
        tick();
        tick();
        check("lbu_wb_data", wb_write_data, 32'h0000_00F5);

        // LH at 0x102, negative upper half
        ex_set(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b1, 5'd11);
        dmem_readdata = 32'h8001_7FFF;
        tick();
        tick();
        check("lh_wb_data", wb_write_data, 32'hFFFF_8001);

        // SB 0xAB at 0x201
        ex_set(1'b1, 1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_56AB, 1'b0, 5'd0);
        tick();
        check("sb_write",  {31'h0, dmem_write}, 32'h1);
        check("sb_read",   {31'h0, dmem_read}, 32'h0);
        check("sb_addr",   dmem_address, 32'h200);
        check("sb_byteen", {28'h0, dmem_byteen}, 32'b0010);
        check("sb_wdata",  dmem_writedata, 32'hABAB_ABAB);
        tick();
        check("sb_write_end", {31'h0, dmem_write}, 32'h0);
        check("sb_stall_end", {31'h0, stall}, 32'h0);
        check("sb_wb_en",     {31'h0, wb_write_reg_en}, 32'h0);

        // SH 0xCAFE at 0x202
        ex_set(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_CAFE, 1'b0, 5'd0);
        tick();
        check("sh_byteen", {28'h0, dmem_byteen}, 32'b1100);
        check("sh_wdata",  dmem_writedata, 32'hCAFE_CAFE);
        tick();

        // read and write together: load wins, unknown funct3 is a word load
        ex_set(1'b1, 1'b1, 1'b1, 3'b011, 32'h500, 32'hFFFF_FFFF, 1'b1, 5'd12);
        dmem_readdata = 32'h1122_3344;
        tick();
        check("rw_read",  {31'h0, dmem_read}, 32'h1);
        check("rw_write", {31'h0, dmem_write}, 32'h0);
        tick();
        check("rw_wb_data", wb_write_data, 32'h1122_3344);
        check("rw_wb_addr", {27'h0, wb_write_address}, 32'd12);

        // reset in the second wait cycle of a load
        ex_set(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd3);
        dmem_busywait = 1'b1;
        dmem_readdata = 32'h5555_AAAA;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstmid_read",  {31'h0, dmem_read}, 32'h0);
        check("rstmid_stall", {31'h0, stall}, 32'h0);
        check("rstmid_wb_en", {31'h0, wb_write_reg_en}, 32'h0);
        reset         = 1'b0;
        dmem_busywait = 1'b0;
        ex_set(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
        tick();
        tick();
        check("rstmid_no_wb", {31'h0, wb_write_reg_en}, 32'h0);
        check("rstmid_idle",  {31'h0, stall}, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_set(1'b1, 1'b0, 1'b1, 3'b010, 32'h302, 32'h0F0F_0F0F, 1'b0, 5'd0);
        tick();
        check("mis_flag",  {31'h0, misalign}, 32'h1);
        check("mis_write", {31'h0, dmem_write}, 32'h0);
        check("mis_stall", {31'h0, stall}, 32'h0);
        check("mis_wb_en", {31'h0, wb_write_reg_en}, 32'h0);
        ex_set(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
        tick();
        check("mis_pulse", {31'h0, misalign}, 32'h0);
        check("mis_idle",  {31'h0, stall}, 32'h0);
`else
        ex_set(1'b1, 1'b0, 1'b1, 3'b010, 32'h302, 32'h0F0F_0F0F, 1'b0, 5'd0);
        tick();
        check("sw_write",  {31'h0, dmem_write}, 32'h1);
        check("sw_addr",   dmem_address, 32'h300);
        check("sw_byteen", {28'h0, dmem_byteen}, 32'b1111);
        check("sw_wdata",  dmem_writedata, 32'h0F0F_0F0F);
        tick();
        check("sw_done", {31'h0, dmem_write}, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
